// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (A)
// and load/multi-cycle (B) writeback, with a registered write stage and pending mask.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  input  logic [ADDR_WIDTH-1:0]      a_addr,
  input  logic [DATA_WIDTH-1:0]      a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [ADDR_WIDTH-1:0]      b_addr,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       b_ready,
  input  logic                       stall,
  output logic [ADDR_WIDTH-1:0]      rf_write,
  output logic [DATA_WIDTH-1:0]      rf_write_data,
  output logic                       rf_write_enable,
  output logic [(2**ADDR_WIDTH)-1:0] pending_mask
);

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  grant_e                       r_last_grant;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]        r_data;
  logic                         r_we;

  logic                         w_grant_a;
  logic                         w_grant_b;
  logic [ADDR_WIDTH-1:0]        w_win_addr;
  logic [DATA_WIDTH-1:0]        w_win_data;
  logic [(2**ADDR_WIDTH)-1:0]   w_mask;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_grant_a  = 1'b0;
    w_grant_b  = 1'b0;
    w_win_addr = a_addr;
    w_win_data = a_data;
    if (!stall) begin
      if (a_valid && (!b_valid || r_last_grant == GNT_B)) begin
        w_grant_a = 1'b1;
      end else if (b_valid) begin
        w_grant_b  = 1'b1;
        w_win_addr = b_addr;
        w_win_data = b_data;
      end
    end
  end

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: async reset clears every register here; the output stage is tiny flops, not memory.
      r_last_grant <= GNT_B;
      r_addr       <= '0;
      r_data       <= '0;
      r_we         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      r_we <= 1'b0;
      if (w_grant_a || w_grant_b) begin
        r_last_grant <= w_grant_a ? GNT_A : GNT_B;
        r_addr       <= w_win_addr;
        r_data       <= w_win_data;
        r_we         <= (w_win_addr != '0);
      end
    end
  end

  assign rf_write        = r_addr;
  assign rf_write_data   = r_data;
  assign rf_write_enable = r_we;

  // Requested or in-flight destinations; register 0 is never a hazard.
  always_comb begin
    w_mask = '0;
    if (a_valid) w_mask[a_addr] = 1'b1;
    if (b_valid) w_mask[b_addr] = 1'b1;
    if (r_we)    w_mask[r_addr] = 1'b1;
    w_mask[0] = 1'b0;
  end

  assign pending_mask = w_mask;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; a behavioural register file sits on
// the write port so end-of-scenario register contents can be checked.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        stall;
  logic [4:0]  rf_write;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [31:0] pending_mask;

  logic [31:0] tb_rf [32];
  int n_pass;
  int n_total;

  regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a_valid         (a_valid),
    .a_addr          (a_addr),
    .a_data          (a_data),
    .a_ready         (a_ready),
    .b_valid         (b_valid),
    .b_addr          (b_addr),
    .b_data          (b_data),
    .b_ready         (b_ready),
    .stall           (stall),
    .rf_write        (rf_write),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .pending_mask    (pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_write_enable) tb_rf[rf_write] <= rf_write_data;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    chk("reset rf_write", {27'd0, rf_write}, 32'd0);
    chk("reset rf_write_data", rf_write_data, 32'd0);
    chk("reset rf_write_enable", {31'd0, rf_write_enable}, 32'd0);
    chk("reset pending_mask", pending_mask, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hDEADBEEF;
    #1;
    chk("single a_ready", {31'd0, a_ready}, 32'd1);
    chk("single b_ready", {31'd0, b_ready}, 32'd0);
    chk("single mask req", pending_mask, 32'h8);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("single rf_write", {27'd0, rf_write}, 32'd3);
    chk("single rf_write_data", rf_write_data, 32'hDEADBEEF);
    chk("single rf_write_enable", {31'd0, rf_write_enable}, 32'd1);
    chk("single mask inflight", pending_mask, 32'h8);
    @(negedge clk); #1;
    chk("single enable drop", {31'd0, rf_write_enable}, 32'd0);
    chk("single reg3", tb_rf[3], 32'hDEADBEEF);
    chk("single mask clear", pending_mask, 32'd0);
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
    #1;
    chk("zero b_ready", {31'd0, b_ready}, 32'd1);
    chk("zero mask req", pending_mask, 32'd0);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("zero rf_write_enable", {31'd0, rf_write_enable}, 32'd0);
    chk("zero rf_write_data", rf_write_data, 32'hFFFFFFFF);
    chk("zero mask inflight", pending_mask, 32'd0);
    @(negedge clk); #1;
    chk("zero reg0", tb_rf[0], 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [4:0] prev_addr;
    prev_addr = 5'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h11;
      b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h22;
      #1;
      chk($sformatf("rr a_ready %0d", i), {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr b_ready %0d", i), {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk($sformatf("rr rf_write %0d", i), {27'd0, rf_write}, {27'd0, prev_addr});
      prev_addr = (i % 2 == 0) ? 5'd4 : 5'd5;
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("rr last rf_write", {27'd0, rf_write}, 32'd5);
    chk("rr last data", rf_write_data, 32'h22);
    @(negedge clk); #1;
    chk("rr reg4", tb_rf[4], 32'h11);
    chk("rr reg5", tb_rf[5], 32'h22);
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBB;
    #1;
    chk("same a first", {31'd0, a_ready}, 32'd1);
    chk("same b waits", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("same b second", {31'd0, b_ready}, 32'd1);
    chk("same first data", rf_write_data, 32'hAA);
    @(negedge clk);
    b_valid = 1'b0;
    #1;
    chk("same second data", rf_write_data, 32'hBB);
    @(negedge clk); #1;
    chk("same reg7 final", tb_rf[7], 32'hBB);
  endtask

  task automatic test_stall();
    @(negedge clk);
    stall = 1'b1;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall a_ready %0d", i), {31'd0, a_ready}, 32'd0);
      chk($sformatf("stall mask9 %0d", i), {31'd0, pending_mask[9]}, 32'd1);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("stall release a_ready", {31'd0, a_ready}, 32'd1);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    chk("stall rf_write", {27'd0, rf_write}, 32'd9);
    chk("stall enable", {31'd0, rf_write_enable}, 32'd1);
    chk("stall mask9 inflight", {31'd0, pending_mask[9]}, 32'd1);
    @(negedge clk); #1;
    chk("stall mask9 clear", {31'd0, pending_mask[9]}, 32'd0);
    chk("stall reg9", tb_rf[9], 32'h99);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0C0;
    #1;
    chk("midrst a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst enable drop", {31'd0, rf_write_enable}, 32'd0);
    chk("midrst rf_write", {27'd0, rf_write}, 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("midrst reg12", tb_rf[12], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2;
    #1;
    chk("midrst a wins", {31'd0, a_ready}, 32'd1);
    chk("midrst b loses", {31'd0, b_ready}, 32'd0);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    for (int i = 0; i < 32; i++) tb_rf[i] = 32'd0;
    rst_n = 1'b0; stall = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    test_reset();
    test_single_a();
    test_zero_reg();
    test_back_to_back();
    test_same_addr();
    test_stall();
    test_reset_midop();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters.
  - Requester A: ALU writeback.
  - Requester B: load / multi-cycle unit writeback.
- Round-robin arbitration with valid/ready handshakes.
- One registered output stage drives the register file write port (write address, write data, write enable).
- Publishes a pending-write mask so the issue/hazard logic can stall readers of registers with writes in flight.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, width of register address; register count = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_WIDTH  requester A destination register.
- a_data  input  DATA_WIDTH  requester A write data.
- a_ready  output  1  requester A granted this cycle; transfer occurs when a_valid and a_ready are both high.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_WIDTH  requester B destination register.
- b_data  input  DATA_WIDTH  requester B write data.
- b_ready  output  1  requester B granted this cycle.
- stall  input  1  blocks all grants while high.
- rf_write  output  ADDR_WIDTH  register file write address (registered).
- rf_write_data  output  DATA_WIDTH  register file write data (registered).
- rf_write_enable  output  1  register file write enable (registered).
- pending_mask  output  2**ADDR_WIDTH  bit r set when a write to register r is requested or in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_write = 0, rf_write_data = 0, rf_write_enable = 0.
  - last_grant = B, so A wins the first contention.
  - Reset mid-operation drops any in-flight write; no partial transfer.
- Grant logic (combinational, from current inputs and last_grant):
  - stall high: a_ready = b_ready = 0.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - At most one ready is high per cycle; ready is never high without the matching valid.
- Round-robin state:
  - last_grant updates to the granted requester on each granted cycle.
  - last_grant holds on idle or stalled cycles.
  - Worst-case wait for a continuously valid requester is 1 cycle.
- Output stage, on a grant at cycle N, in cycle N+1:
  - rf_write and rf_write_data capture the winner's addr/data.
  - rf_write_enable = 1 if winner addr != 0, else 0.
  - Zero-register writes are accepted (handshake completes) but never enabled.
- No grant in cycle N: rf_write_enable = 0 in cycle N+1; rf_write and rf_write_data hold their previous values.
- Latency: request accepted in cycle N; register file updated at the rising edge ending cycle N+1; readable from cycle N+2.
- Requester rules:
  - Requesters hold valid, addr and data stable until ready.
  - The arbiter does not buffer ungranted requests.
- Same destination from A and B in the same cycle: both are serialized in grant order; the later grant's data is the final register value.
- pending_mask (combinational):
  - Set bit a_addr if a_valid.
  - Set bit b_addr if b_valid.
  - Set bit rf_write if rf_write_enable.
  - Bit 0 is always 0.
  - Bits clear the cycle after the write enable cycle.
- stall high for several cycles:
  - No handshakes complete.
  - An already-registered write still completes (rf_write_enable drops the following cycle).
  - pending_mask continues to reflect valid requests.

Test Plan:
- Reset release, A valid (addr 3, data 0xDEADBEEF) → a_ready=1 in cycle N; rf_write=3, rf_write_data=0xDEADBEEF, rf_write_enable=1 in N+1; register 3 reads 0xDEADBEEF in N+2.
- A and B valid continuously (A: addr 4, data 0x11; B: addr 5, data 0x22) for 4 cycles → grants alternate A, B, A, B; rf_write sequence 4, 5, 4, 5.
- A and B both target addr 7 (A data 0xAA, B data 0xBB) at the same time, both held until accepted → A granted first, then B; register 7 ends at 0xBB.
- B valid with addr 0, data 0xFFFFFFFF → b_ready=1; rf_write_enable stays 0; register 0 unchanged; pending_mask bit 0 stays 0.
- stall=1 for 3 cycles with A valid (addr 9) → a_ready=0 throughout; pending_mask bit 9 stays set; after stall drops, A is granted next cycle and bit 9 clears the cycle after rf_write_enable.
- rst_n asserted the cycle after a grant to addr 12 → rf_write_enable drops to 0 immediately; register 12 not written; after release, A wins the first A/B contention.
